alien_spawn_scheduler: RTL and testbench
========================================

ALIEN_SPAWN_SCHEDULER -- requirements
Module: alien_spawn_scheduler

Interface
REQ-001 SHALL have parameter SPAWN_INTERVAL, default 120, frames between successive spawns.
REQ-002 SHALL have parameter TOTAL_ALIENS, default 8, aliens per level (range 1..31).
REQ-003 SHALL have parameter MAX_ACTIVE, default 3, maximum concurrently active aliens (range 1..4).
REQ-004 SHALL have parameter DEATH_FREEZE, default 60, frames frozen after player death.
REQ-005 SHALL have parameter CLEAR_FRAMES, default 90, frames between level clear and next level.
REQ-006 SHALL have port clk  input  1  system clock (clk_25 domain).
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port startOfFrame  input  1  one-cycle pulse at pixel (0,0).
REQ-009 SHALL have port alien_died  input  4  per-slot one-cycle kill pulse from game_controller.
REQ-010 SHALL have port player_died  input  1  one-cycle player-hit pulse.
REQ-011 SHALL have port spawn_point_free  input  1  high when the spawn cell holds no object.
REQ-012 SHALL have port alien_active  output  4  per-slot enable to alien blocks.
REQ-013 SHALL have port alien_spawn  output  4  per-slot one-cycle load pulse (alien block resets to spawn cell).
REQ-014 SHALL have port alive_count  output  3  popcount of alien_active.
REQ-015 SHALL have port remaining  output  5  aliens not yet spawned this level.
REQ-016 SHALL have port level_clear  output  1  one-cycle level-complete pulse.
REQ-017 SHALL have port level_num  output  4  current level, saturating at 15.
REQ-018 SHALL have port sched_state  output  2  RUN=0, FREEZE=1, CLEAR=2.

Function
REQ-019 SHALL implement FSM states RUN, FREEZE, CLEAR; all outputs registered.
REQ-020 SHALL keep an 8-bit frame counter incremented on startOfFrame, saturating at the active state's threshold.
REQ-021 In RUN, on startOfFrame with counter >= SPAWN_INTERVAL, remaining > 0, alive_count < MAX_ACTIVE and spawn_point_free, SHALL spawn into the lowest-index inactive slot.
REQ-022 A spawn SHALL, in the cycle after startOfFrame: pulse alien_spawn[i] for exactly one cycle, set alien_active[i], decrement remaining, clear counter.
REQ-023 If any spawn condition fails, counter SHALL hold at SPAWN_INTERVAL and the spawn SHALL retry on each later startOfFrame.
REQ-024 At most one spawn SHALL occur per frame.
REQ-025 alien_died[i] with alien_active[i]=1 SHALL clear alien_active[i] next cycle; alien_died on an inactive slot SHALL be ignored.
REQ-026 A death and a spawn in the same cycle SHALL both take effect; a spawn never targets the dying slot because selection uses pre-update alien_active.
REQ-027 alive_count SHALL equal popcount(alien_active) in the same cycle alien_active changes.
REQ-028 In RUN, player_died SHALL: clear all alien_active, add popcount(alien_active & ~alien_died) to remaining, clear counter, and enter FREEZE.
REQ-029 player_died SHALL take priority over a same-cycle spawn, which is suppressed.
REQ-030 FREEZE SHALL suppress spawning and return to RUN with counter=0 once DEATH_FREEZE frames have elapsed.
REQ-031 In RUN, remaining==0 and alien_active==0 SHALL cause entry to CLEAR, a single-cycle level_clear pulse, and a saturating increment of level_num.
REQ-032 After CLEAR_FRAMES frames, CLEAR SHALL reload remaining=TOTAL_ALIENS, clear counter, and return to RUN.
REQ-033 player_died and alien_died SHALL be ignored in FREEZE and CLEAR.

Reset
REQ-034 While reset=1 at a clk edge, SHALL set: state RUN, counter 0, alien_active 0, alien_spawn 0, alive_count 0, remaining TOTAL_ALIENS, level_clear 0, level_num 0.
REQ-035 Reset SHALL override all inputs, including mid-FREEZE or mid-CLEAR.

Verification
REQ-036 Defaults, spawn_point_free=1, 120 frames after reset -> alien_spawn=0001 one cycle, alien_active=0001, remaining=7.
REQ-037 Run 480 frames with no deaths -> exactly 3 spawns (slots 0,1,2), no fourth spawn, remaining=5, counter held at 120.
REQ-038 Active=0111, pulse alien_died=0010 on the spawn cycle -> active becomes 0101 then slot 1 respawns next eligible frame; with spawn_point_free=0, no spawn until it rises.
REQ-039 Active=0011, remaining=5, player_died with alien_died=0001 same cycle -> active=0000, remaining=6, FREEZE for 60 frames, first spawn 120 frames after returning to RUN.
REQ-040 Kill all 8 aliens -> single level_clear pulse, level_num=1, CLEAR for 90 frames, remaining=8, RUN.
REQ-041 Assert reset during CLEAR -> next cycle sched_state=0, level_num=0, remaining=8, alien_active=0000.

Source files
------------

// File: rtl/alien_spawn_scheduler.sv
// Alien spawn scheduler: paces alien spawns per frame, tracks live/remaining
// aliens per level, freezes after player death and pauses between levels.
module alien_spawn_scheduler #(
   parameter int SPAWN_INTERVAL = 120,
   parameter int TOTAL_ALIENS   = 8,
   parameter int MAX_ACTIVE     = 3,
   parameter int DEATH_FREEZE   = 60,
   parameter int CLEAR_FRAMES   = 90
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic [3:0] alien_died,
   input  logic       player_died,
   input  logic       spawn_point_free,
   output logic [3:0] alien_active,
   output logic [3:0] alien_spawn,
   output logic [2:0] alive_count,
   output logic [4:0] remaining,
   output logic       level_clear,
   output logic [3:0] level_num,
   output logic [1:0] sched_state
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FREEZE = 2'd1,
      ST_CLEAR  = 2'd2
   } state_e;

   localparam logic [7:0] SPAWN_TH  = 8'(SPAWN_INTERVAL);
   localparam logic [7:0] FREEZE_TH = 8'(DEATH_FREEZE);
   localparam logic [7:0] CLEAR_TH  = 8'(CLEAR_FRAMES);
   localparam logic [2:0] MAX_ACT   = 3'(MAX_ACTIVE);
   localparam logic [4:0] TOTAL     = 5'(TOTAL_ALIENS);

   // Number of set bits in a 4-bit slot mask.
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // One-hot of the lowest-index clear bit (zero when all slots are taken).
   function automatic logic [3:0] lowest_free(input logic [3:0] act);
      if (!act[0]) begin
         lowest_free = 4'b0001;
      end else if (!act[1]) begin
         lowest_free = 4'b0010;
      end else if (!act[2]) begin
         lowest_free = 4'b0100;
      end else if (!act[3]) begin
         lowest_free = 4'b1000;
      end else begin
         lowest_free = 4'b0000;
      end
   endfunction

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] active_q, active_d;
   logic [3:0] spawn_q, spawn_d;
   logic [2:0] alive_q, alive_d;
   logic [4:0] remaining_q, remaining_d;
   logic       level_clear_q, level_clear_d;
   logic [3:0] level_num_q, level_num_d;

   logic [7:0] thresh_s;
   logic [7:0] cnt_inc_s;
   logic [3:0] live_s;

   // Next-state logic: frame pacing, slot allocation, deaths and level flow.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      active_d      = active_q;
      spawn_d       = 4'b0000;
      remaining_d   = remaining_q;
      level_clear_d = 1'b0;
      level_num_d   = level_num_q;
      live_s        = active_q & ~alien_died;
      thresh_s      = SPAWN_TH;
      cnt_inc_s     = cnt_q;

      case (state_q)
         ST_RUN:    thresh_s = SPAWN_TH;
         ST_FREEZE: thresh_s = FREEZE_TH;
         ST_CLEAR:  thresh_s = CLEAR_TH;
         default:   thresh_s = SPAWN_TH;
      endcase

      // Frame counter saturates at the threshold of the current state.
      if (cnt_q >= thresh_s) begin
         cnt_inc_s = thresh_s;
      end else begin
         cnt_inc_s = cnt_q + 8'd1;
      end

      case (state_q)
         ST_RUN: begin
            if (player_died) begin
               // Surviving aliens go back into the pool for the next attempt.
               active_d    = 4'b0000;
               remaining_d = remaining_q + {2'b00, popcount4(live_s)};
               cnt_d       = 8'd0;
               state_d     = ST_FREEZE;
            end else if ((remaining_q == 5'd0) && (active_q == 4'b0000)) begin
               state_d       = ST_CLEAR;
               cnt_d         = 8'd0;
               level_clear_d = 1'b1;
               if (level_num_q == 4'd15) begin
                  level_num_d = 4'd15;
               end else begin
                  level_num_d = level_num_q + 4'd1;
               end
            end else begin
               active_d = live_s;
               if (startOfFrame) begin
                  // Slot choice and capacity use pre-death occupancy so a dying
                  // slot is never reloaded in the same cycle.
                  if ((cnt_inc_s >= SPAWN_TH) && (remaining_q != 5'd0) &&
                      (alive_q < MAX_ACT) && spawn_point_free) begin
                     spawn_d     = lowest_free(active_q);
                     active_d    = live_s | spawn_d;
                     remaining_d = remaining_q - 5'd1;
                     cnt_d       = 8'd0;
                  end else begin
                     cnt_d = cnt_inc_s;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         ST_FREEZE: begin
            if (startOfFrame) begin
               if (cnt_inc_s >= FREEZE_TH) begin
                  state_d = ST_RUN;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_CLEAR: begin
            if (startOfFrame) begin
               if (cnt_inc_s >= CLEAR_TH) begin
                  state_d     = ST_RUN;
                  cnt_d       = 8'd0;
                  remaining_d = TOTAL;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 8'd0;
         end
      endcase

      alive_d = popcount4(active_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         cnt_q         <= 8'd0;
         active_q      <= 4'b0000;
         spawn_q       <= 4'b0000;
         alive_q       <= 3'd0;
         remaining_q   <= TOTAL;
         level_clear_q <= 1'b0;
         level_num_q   <= 4'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         active_q      <= active_d;
         spawn_q       <= spawn_d;
         alive_q       <= alive_d;
         remaining_q   <= remaining_d;
         level_clear_q <= level_clear_d;
         level_num_q   <= level_num_d;
      end
   end

   assign alien_active = active_q;
   assign alien_spawn  = spawn_q;
   assign alive_count  = alive_q;
   assign remaining    = remaining_q;
   assign level_clear  = level_clear_q;
   assign level_num    = level_num_q;
   assign sched_state  = state_q;

endmodule

// File: tb/tb_alien_spawn_scheduler.sv
// Self-checking bench for alien_spawn_scheduler: directed level scenarios
// followed by randomized traffic, all checked against a frame-level model.
module tb_alien_spawn_scheduler;

   localparam int SI = 120;
   localparam int TA = 8;
   localparam int MA = 3;
   localparam int DF = 60;
   localparam int CF = 90;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startOfFrame = 1'b0;
   logic [3:0] alien_died = 4'b0000;
   logic       player_died = 1'b0;
   logic       spawn_point_free = 1'b1;
   logic [3:0] alien_active;
   logic [3:0] alien_spawn;
   logic [2:0] alive_count;
   logic [4:0] remaining;
   logic       level_clear;
   logic [3:0] level_num;
   logic [1:0] sched_state;

   int checks = 0;
   int failures = 0;
   int spawn_seen = 0;
   int clear_seen = 0;

   // Reference model state (mode: 0 run, 1 freeze, 2 clear).
   int       m_mode = 0;
   int       m_frames = 0;
   bit [3:0] m_active = 4'b0000;
   bit [3:0] m_spawn = 4'b0000;
   int       m_remaining = TA;
   int       m_level = 0;
   bit       m_clear = 1'b0;

   alien_spawn_scheduler #(
      .SPAWN_INTERVAL(SI), .TOTAL_ALIENS(TA), .MAX_ACTIVE(MA),
      .DEATH_FREEZE(DF), .CLEAR_FRAMES(CF)
   ) dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .alien_died(alien_died), .player_died(player_died),
      .spawn_point_free(spawn_point_free), .alien_active(alien_active),
      .alien_spawn(alien_spawn), .alive_count(alive_count),
      .remaining(remaining), .level_clear(level_clear),
      .level_num(level_num), .sched_state(sched_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Frame-level behaviour: what one clock edge does given these inputs.
   task automatic model_step(input bit r, input bit s, input bit [3:0] d, input bit p, input bit f);
      bit [3:0] next_act;
      int survivors;
      m_spawn = 4'b0000;
      m_clear = 1'b0;
      if (r) begin
         m_mode = 0; m_frames = 0; m_active = 4'b0000;
         m_remaining = TA; m_level = 0;
         return;
      end
      if (m_mode == 0) begin
         survivors = 0;
         for (int i = 0; i < 4; i++) if (m_active[i] && !d[i]) survivors++;
         if (p) begin
            m_remaining += survivors;
            m_active = 4'b0000;
            m_frames = 0;
            m_mode = 1;
         end else if (m_remaining == 0 && m_active == 4'b0000) begin
            m_mode = 2;
            m_frames = 0;
            m_clear = 1'b1;
            m_level = (m_level < 15) ? m_level + 1 : 15;
         end else begin
            next_act = m_active & ~d;
            if (s) begin
               m_frames = (m_frames + 1 > SI) ? SI : m_frames + 1;
               if (m_frames >= SI && m_remaining > 0 && $countones(m_active) < MA && f) begin
                  for (int i = 3; i >= 0; i--) if (!m_active[i]) m_spawn = 4'b0001 << i;
                  next_act |= m_spawn;
                  m_remaining--;
                  m_frames = 0;
               end
            end
            m_active = next_act;
         end
      end else if (s) begin
         m_frames++;
         if (m_mode == 1 && m_frames >= DF) begin
            m_mode = 0; m_frames = 0;
         end else if (m_mode == 2 && m_frames >= CF) begin
            m_mode = 0; m_frames = 0; m_remaining = TA;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("active", alien_active, m_active);
      check_eq("spawn", alien_spawn, m_spawn);
      check_eq("alive", alive_count, $countones(m_active));
      check_eq("remaining", remaining, m_remaining);
      check_eq("level_clear", level_clear, m_clear);
      check_eq("level_num", level_num, m_level);
      check_eq("state", sched_state, m_mode);
      if (alien_spawn != 4'b0000) spawn_seen++;
      if (level_clear) clear_seen++;
      if (failures >= 40) finish_run();
   endtask

   task automatic cycle(input bit r, input bit s, input bit [3:0] d, input bit p, input bit f);
      reset = r; startOfFrame = s; alien_died = d; player_died = p; spawn_point_free = f;
      model_step(r, s, d, p, f);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic frames(input int n, input bit f);
      for (int k = 0; k < n; k++) begin
         cycle(1'b0, 1'b1, 4'b0000, 1'b0, f);
         cycle(1'b0, 1'b0, 4'b0000, 1'b0, f);
         cycle(1'b0, 1'b0, 4'b0000, 1'b0, f);
      end
   endtask

   task automatic gap2();
      cycle(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
   endtask

   // Kill every alien as soon as it appears until the level clears.
   task automatic kill_until_clear();
      clear_seen = 0;
      for (int k = 0; k < 1300 && clear_seen == 0; k++) begin
         cycle(1'b0, 1'b1, m_active, 1'b0, 1'b1);
         gap2();
      end
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: run did not finish within time limit");
      finish_run();
   end

   initial begin
      bit [3:0] d;
      int gap;
      cycle(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
      check_eq("rst_state", sched_state, 2'd0);
      check_eq("rst_remaining", remaining, 5'd8);
      check_eq("rst_active", alien_active, 4'b0000);

      // First spawn lands on the 120th frame.
      spawn_seen = 0;
      frames(119, 1'b1);
      check_eq("pre_spawn_active", alien_active, 4'b0000);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      check_eq("first_spawn", alien_spawn, 4'b0001);
      check_eq("first_active", alien_active, 4'b0001);
      check_eq("first_remaining", remaining, 5'd7);
      gap2();
      check_eq("spawn_one_cycle", alien_spawn, 4'b0000);

      // Capacity limit: 480 frames yields exactly three spawns.
      frames(360, 1'b1);
      check_eq("spawns_480", spawn_seen, 3);
      check_eq("active_480", alien_active, 4'b0111);
      check_eq("remaining_480", remaining, 5'd5);

      // Death on a would-be spawn frame, then blocked spawn point.
      cycle(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
      check_eq("death_active", alien_active, 4'b0101);
      check_eq("death_no_spawn", alien_spawn, 4'b0000);
      gap2();
      frames(5, 1'b0);
      check_eq("blocked_active", alien_active, 4'b0101);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      check_eq("respawn_slot1", alien_spawn, 4'b0010);
      check_eq("respawn_active", alien_active, 4'b0111);
      gap2();

      // Player death with a simultaneous alien kill.
      cycle(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
      check_eq("pd_pre_active", alien_active, 4'b0011);
      cycle(1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
      check_eq("pd_active", alien_active, 4'b0000);
      check_eq("pd_remaining", remaining, 5'd5);
      check_eq("pd_state", sched_state, 2'd1);
      cycle(1'b0, 1'b0, 4'b0010, 1'b1, 1'b1);
      check_eq("freeze_ignore", remaining, 5'd5);
      frames(59, 1'b1);
      check_eq("freeze_hold", sched_state, 2'd1);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      check_eq("freeze_exit", sched_state, 2'd0);
      gap2();
      frames(119, 1'b1);
      check_eq("post_freeze_wait", alien_active, 4'b0000);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      check_eq("post_freeze_spawn", alien_spawn, 4'b0001);
      gap2();

      // Level clear and the pause before the next level.
      kill_until_clear();
      check_eq("clear_pulses", clear_seen, 1);
      check_eq("clear_level", level_num, 4'd1);
      check_eq("clear_state", sched_state, 2'd2);
      frames(89, 1'b1);
      check_eq("clear_hold", sched_state, 2'd2);
      cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      check_eq("clear_exit", sched_state, 2'd0);
      check_eq("clear_reload", remaining, 5'd8);
      gap2();

      // Reset in the middle of CLEAR.
      kill_until_clear();
      check_eq("clear2_level", level_num, 4'd2);
      frames(10, 1'b1);
      cycle(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
      check_eq("rst_clear_state", sched_state, 2'd0);
      check_eq("rst_clear_level", level_num, 4'd0);
      check_eq("rst_clear_rem", remaining, 5'd8);
      check_eq("rst_clear_active", alien_active, 4'b0000);

      // Randomized traffic against the model.
      gap = 0;
      for (int k = 0; k < 9000; k++) begin
         d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         cycle(($urandom_range(0, 2999) == 0), (gap == 0), d,
               ($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0));
         gap = (gap == 0) ? $urandom_range(1, 4) : gap - 1;
      end

      finish_run();
   end

endmodule
